// File: rtl/pipe_skid_pkg.sv
// Shared types and constants for the pipe_skid register slice.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 4;
  localparam int unsigned STALL_W    = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_if.sv
// Upstream and downstream valid/ready handshake bundle for pipe_skid.
interface pipe_skid_if #(
  parameter int unsigned WIDTH = pipe_pkg::PIPE_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_skid_reg_en.sv
// WIDTH-bit data register with load enable and synchronous reset to zero.
module pipe_reg_en #(
  parameter int unsigned WIDTH = pipe_pkg::PIPE_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry valid/ready skid slice: main register drives out_data, skid absorbs one beat.
// Optional stall counter port stall_cnt enabled by PIPE_SKID_STATS_EN.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  pipe_skid_if.slave bus
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_e           state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decode the state register only, keeping both sides registered.
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_data  = main_q;

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_d   = bus.in_data;
    in_fire  = bus.in_valid && (state_q != FULL);
    out_fire = bus.out_ready && (state_q != EMPTY);
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  pipe_reg_en #(.WIDTH(WIDTH)) u_main (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (main_en),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (skid_en),
    .d_i     (bus.in_data),
    .q_o     (skid_q)
  );

`ifdef PIPE_SKID_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Directed and random self-checking bench for pipe_skid; stall counter checks under PIPE_SKID_STATS_EN.
module tb_pipe_skid;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_skid_if #(.WIDTH(W)) bus ();

`ifdef PIPE_SKID_STATS_EN
  logic [7:0] stall_cnt;
`endif

  pipe_skid #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hA;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_chk++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
`ifdef PIPE_SKID_STATS_EN
    n_chk++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_discard got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_stream;
    logic [3:0] v;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      v            = 4'(i);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, bus.in_ready); end
      tick();
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d] got %b exp 1", i, bus.out_valid); end
      n_chk++; if (bus.out_data !== v) begin n_fail++; $display("FAIL stream_out_data[%0d] got %h exp %h", i, bus.out_data, v); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_single_stall;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h4;
    tick();
    n_chk++; if (bus.out_data !== 4'h4) begin n_fail++; $display("FAIL ss_first got %h exp 4", bus.out_data); end
    bus.in_data = 4'h5;
    tick();
    n_chk++; if (bus.out_data !== 4'h5) begin n_fail++; $display("FAIL ss_five got %h exp 5", bus.out_data); end
    bus.out_ready = 1'b0;
    bus.in_data   = 4'h6;
    tick();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ss_full_in_ready got %b exp 0", bus.in_ready); end
    n_chk++; if (bus.out_data !== 4'h5) begin n_fail++; $display("FAIL ss_hold got %h exp 5", bus.out_data); end
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ss_hold_valid got %b exp 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    bus.in_data   = 4'h7;
    tick();
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ss_recover_in_ready got %b exp 1", bus.in_ready); end
    n_chk++; if (bus.out_data !== 4'h6) begin n_fail++; $display("FAIL ss_skid_out got %h exp 6", bus.out_data); end
    tick();
    n_chk++; if (bus.out_data !== 4'h7) begin n_fail++; $display("FAIL ss_seven got %h exp 7", bus.out_data); end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ss_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_long_stall;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hA;
    tick();
    bus.out_ready = 1'b0;
    bus.in_data   = 4'hB;
    for (int c = 1; c <= 10; c++) begin
      n_chk++; if (bus.in_ready !== (c == 1)) begin n_fail++; $display("FAIL ls_in_ready[%0d] got %b exp %b", c, bus.in_ready, (c == 1)); end
      tick();
      bus.in_data = 4'hC;
      n_chk++; if (bus.out_data !== 4'hA) begin n_fail++; $display("FAIL ls_hold[%0d] got %h exp a", c, bus.out_data); end
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ls_valid[%0d] got %b exp 1", c, bus.out_valid); end
    end
`ifdef PIPE_SKID_STATS_EN
    n_chk++; if (stall_cnt !== 8'd10) begin n_fail++; $display("FAIL ls_stall_cnt got %0d exp 10", stall_cnt); end
`endif
    bus.out_ready = 1'b1;
    tick();
    n_chk++; if (bus.out_data !== 4'hB) begin n_fail++; $display("FAIL ls_rel_b got %h exp b", bus.out_data); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ls_rel_in_ready got %b exp 1", bus.in_ready); end
    tick();
    n_chk++; if (bus.out_data !== 4'hC) begin n_fail++; $display("FAIL ls_rel_c got %h exp c", bus.out_data); end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ls_drain got %b exp 0", bus.out_valid); end
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_saturation;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h3;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 254) begin
        n_chk++; if (stall_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d exp 254", stall_cnt); end
      end
      if (c == 255 || c == 300) begin
        n_chk++; if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_%0d got %0d exp 255", c, stall_cnt); end
      end
    end
    n_chk++; if (bus.out_data !== 4'h3) begin n_fail++; $display("FAIL sat_hold got %h exp 3", bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
  endtask
`endif

  task automatic test_mid_reset;
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h1;
    tick();
    bus.in_data = 4'h2;
    tick();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_full got %b exp 0", bus.in_ready); end
    reset         = 1'b1;
    bus.in_data   = 4'h3;
    bus.out_ready = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready got %b exp 1", bus.in_ready); end
    n_chk++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL mr_out_data got %h exp 0", bus.out_data); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_emit[%0d] got %b exp 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_random;
    logic [3:0] exp_q[$];
    logic       prev_stall;
    logic [3:0] prev_data;
    int         occ;
    apply_reset();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      occ = exp_q.size();
      n_chk++; if (bus.out_valid !== (occ != 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d] got %b exp %b", c, bus.out_valid, (occ != 0)); end
      n_chk++; if (bus.in_ready !== (occ < 2)) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", c, bus.in_ready, (occ < 2)); end
      if (prev_stall) begin
        n_chk++; if (bus.out_data !== prev_data) begin n_fail++; $display("FAIL rnd_stable[%0d] got %h exp %h", c, bus.out_data, prev_data); end
      end
      if (bus.out_ready && occ != 0) begin
        n_chk++; if (bus.out_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_order[%0d] got %h exp %h", c, bus.out_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      if (bus.in_valid && occ < 2) exp_q.push_back(bus.in_data);
      prev_stall = (occ != 0) && !bus.out_ready;
      prev_data  = bus.out_data;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_single_stall();
    test_long_stall();
`ifdef PIPE_SKID_STATS_EN
    test_saturation();
`endif
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
